linear_weight_dot_accumulator: RTL and testbench



---
 rtl/linear_weight_dot_accumulator.sv | 196 +++++++++++++++++++
 tb/tb_linear_weight_dot_accumulator.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/linear_weight_dot_accumulator.sv
// linear_weight_dot_accumulator
//
// Purpose:
//   Joins an activation stream and a weight stream (PARALLELISM lanes each),
//   multiplies them lane-wise, sums the lane products and accumulates that
//   sum over IN_DEPTH beats.
//   One signed fixed-point dot product is emitted per IN_DEPTH beats over a
//   valid/ready handshake.
//   The binary point of data_out sits at DATA_IN_PRECISION_1 + WEIGHT_PRECISION_1.
//   No realignment is applied.
//
// Build option:
//   ACC_SATURATE_EN  defined   -> the result is clamped to the signed
//                                 OUT_PRECISION range.
//                    undefined -> the result keeps the low OUT_PRECISION bits
//                                 (two's-complement wrap).
//
// Ports:
//   clk            in   clock
//   rst            in   synchronous active-high reset
//   data_in        in   activation lanes, signed, unpacked [PARALLELISM]
//   data_in_valid  in   activations valid
//   data_in_ready  out  activations accepted (only when weights also valid)
//   weight         in   weight lanes, signed, unpacked [PARALLELISM]
//   weight_valid   in   weights valid
//   weight_ready   out  weight source advance (only when activations also valid)
//   data_out       out  signed dot-product result, OUT_PRECISION bits
//   data_out_valid out  result valid, held until data_out_ready
//   data_out_ready in   downstream accepts the result

module linear_weight_dot_accumulator #(
  parameter int DATA_IN_PRECISION_0 = 16,
  parameter int DATA_IN_PRECISION_1 = 3,
  parameter int WEIGHT_PRECISION_0  = 16,
  parameter int WEIGHT_PRECISION_1  = 3,
  parameter int PARALLELISM         = 4,
  parameter int IN_DEPTH            = 8,
  parameter int ACC_WIDTH           = DATA_IN_PRECISION_0 + WEIGHT_PRECISION_0 +
                                      $clog2(PARALLELISM) + $clog2(IN_DEPTH),
  parameter int OUT_PRECISION       = 32
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [DATA_IN_PRECISION_0-1:0] data_in [PARALLELISM],
  input  logic                           data_in_valid,
  output logic                           data_in_ready,
  input  logic [WEIGHT_PRECISION_0-1:0]  weight [PARALLELISM],
  input  logic                           weight_valid,
  output logic                           weight_ready,
  output logic [OUT_PRECISION-1:0]       data_out,
  output logic                           data_out_valid,
  input  logic                           data_out_ready
);

  localparam int PROD_W = DATA_IN_PRECISION_0 + WEIGHT_PRECISION_0;
  localparam int CNT_W  = (IN_DEPTH > 1) ? $clog2(IN_DEPTH) : 1;

  localparam logic [0:0] ST_ACCUM = 1'b0;
  localparam logic [0:0] ST_EMIT  = 1'b1;

  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(IN_DEPTH - 1);

  // Parameter sanity checks, resolved at elaboration.
  if (IN_DEPTH < 1) begin : g_bad_depth
    $error("IN_DEPTH must be >= 1");
  end
  if (OUT_PRECISION > ACC_WIDTH) begin : g_bad_out_width
    $error("OUT_PRECISION must not exceed ACC_WIDTH");
  end
  if (DATA_IN_PRECISION_1 < 0 || WEIGHT_PRECISION_1 < 0) begin : g_bad_frac
    $error("fractional bit counts must be non-negative");
  end

  // ---------------------------------------------------------------------------
  // Lane multipliers and lane-sum adder
  // ---------------------------------------------------------------------------
  logic signed [PROD_W-1:0]    prod     [PARALLELISM];
  logic signed [ACC_WIDTH-1:0] prod_ext [PARALLELISM];
  logic signed [ACC_WIDTH-1:0] lane_sum;

  for (genvar gi = 0; gi < PARALLELISM; gi++) begin : g_lane
    logic signed [DATA_IN_PRECISION_0-1:0] act_s;
    logic signed [WEIGHT_PRECISION_0-1:0]  wgt_s;

    assign act_s = data_in[gi];
    assign wgt_s = weight[gi];
    // Sized casts of signed operands sign-extend, so the product is exact.
    assign prod[gi]     = PROD_W'(act_s) * PROD_W'(wgt_s);
    assign prod_ext[gi] = ACC_WIDTH'(prod[gi]);
  end

  always_comb begin
    lane_sum = '0;
    for (int i = 0; i < PARALLELISM; i++) begin
      lane_sum = lane_sum + prod_ext[i];
    end
  end

  // ---------------------------------------------------------------------------
  // Result conversion to the output width
  // ---------------------------------------------------------------------------
  function automatic logic [OUT_PRECISION-1:0] convert(input logic [ACC_WIDTH-1:0] a);
`ifdef ACC_SATURATE_EN
    logic [ACC_WIDTH-OUT_PRECISION:0] hi;
    // The value fits exactly when all bits from the output sign bit upward agree.
    hi = a[ACC_WIDTH-1:OUT_PRECISION-1];
    if ((&hi) || !(|hi)) begin
      return a[OUT_PRECISION-1:0];
    end else if (a[ACC_WIDTH-1]) begin
      return {1'b1, {(OUT_PRECISION-1){1'b0}}};
    end else begin
      return {1'b0, {(OUT_PRECISION-1){1'b1}}};
    end
`else
    return a[OUT_PRECISION-1:0];
`endif
  endfunction

  // ---------------------------------------------------------------------------
  // Control and state
  // ---------------------------------------------------------------------------
  logic [0:0]                 state_q, state_d;
  logic [CNT_W-1:0]           beat_cnt_q, beat_cnt_d;
  logic signed [ACC_WIDTH-1:0] acc_q, acc_d;
  logic [OUT_PRECISION-1:0]   data_out_q, data_out_d;
  logic                       data_out_valid_q, data_out_valid_d;

  logic                        in_accum;
  logic                        fire;
  logic signed [ACC_WIDTH-1:0] acc_base;
  logic signed [ACC_WIDTH-1:0] acc_sum;

  assign in_accum = (state_q == ST_ACCUM);

  // Join: each ready looks only at the other stream's valid, so neither
  // stream is consumed without its partner.
  assign data_in_ready = !rst && in_accum && weight_valid;
  assign weight_ready  = !rst && in_accum && data_in_valid;
  assign fire          = in_accum && data_in_valid && weight_valid;

  // Beat 0 starts a fresh accumulation.
  // This avoids a separate clear cycle after a result.
  assign acc_base = (beat_cnt_q == '0) ? '0 : acc_q;
  assign acc_sum  = acc_base + lane_sum;

  always_comb begin
    state_d          = state_q;
    beat_cnt_d       = beat_cnt_q;
    acc_d            = acc_q;
    data_out_d       = data_out_q;
    data_out_valid_d = data_out_valid_q;

    case (state_q)
      ST_ACCUM: begin
        if (fire) begin
          acc_d = acc_sum;
          if (beat_cnt_q == LAST_BEAT) begin
            beat_cnt_d       = '0;
            data_out_d       = convert(acc_sum);
            data_out_valid_d = 1'b1;
            state_d          = ST_EMIT;
          end else begin
            beat_cnt_d = beat_cnt_q + 1'b1;
          end
        end
      end
      ST_EMIT: begin
        if (data_out_ready) begin
          data_out_valid_d = 1'b0;
          state_d          = ST_ACCUM;
        end
      end
      default: state_d = ST_ACCUM;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= ST_ACCUM;
      beat_cnt_q       <= '0;
      acc_q            <= '0;
      data_out_q       <= '0;
      data_out_valid_q <= 1'b0;
    end else begin
      state_q          <= state_d;
      beat_cnt_q       <= beat_cnt_d;
      acc_q            <= acc_d;
      data_out_q       <= data_out_d;
      data_out_valid_q <= data_out_valid_d;
    end
  end

  assign data_out       = data_out_q;
  assign data_out_valid = data_out_valid_q;

endmodule

// File: tb/tb_linear_weight_dot_accumulator.sv
// Testbench for linear_weight_dot_accumulator.
// A behavioural model tracks the expected outputs and handshake every cycle.
// Directed scenarios check hand-computed results against literal values.

module tb_linear_weight_dot_accumulator;

  localparam int DW = 16;
  localparam int WW = 16;
  localparam int P  = 4;
  localparam int D  = 8;
  localparam int OW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] data_in [P];
  logic          data_in_valid = 1'b0;
  logic          data_in_ready;
  logic [WW-1:0] weight [P];
  logic          weight_valid = 1'b0;
  logic          weight_ready;
  logic [OW-1:0] data_out;
  logic          data_out_valid;
  logic          data_out_ready = 1'b1;

  always #5 clk = ~clk;

  linear_weight_dot_accumulator #(
    .DATA_IN_PRECISION_0(DW),
    .DATA_IN_PRECISION_1(3),
    .WEIGHT_PRECISION_0(WW),
    .WEIGHT_PRECISION_1(3),
    .PARALLELISM(P),
    .IN_DEPTH(D),
    .OUT_PRECISION(OW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .data_in(data_in),
    .data_in_valid(data_in_valid),
    .data_in_ready(data_in_ready),
    .weight(weight),
    .weight_valid(weight_valid),
    .weight_ready(weight_ready),
    .data_out(data_out),
    .data_out_valid(data_out_valid),
    .data_out_ready(data_out_ready)
  );

  int checks   = 0;
  int errors   = 0;
  bit check_en = 1'b0;
  int cyc      = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model: plain integer dot products grouped by D beats
  // ---------------------------------------------------------------------------
  bit          m_emit  = 1'b0;
  int          m_beats = 0;
  longint      m_acc   = 0;
  logic [31:0] m_out   = '0;

  function automatic logic [31:0] conv(input longint a);
    longint lo;
    longint hi;
    lo = -(longint'(1) << (OW - 1));
    hi = (longint'(1) << (OW - 1)) - 1;
`ifdef ACC_SATURATE_EN
    if (a > hi) return hi[31:0];
    if (a < lo) return lo[31:0];
    return a[31:0];
`else
    return a[31:0];
`endif
  endfunction

  always @(posedge clk) begin
    longint s;
    cyc++;
    if (rst) begin
      m_emit  = 1'b0;
      m_beats = 0;
      m_acc   = 0;
      m_out   = '0;
    end else if (!m_emit) begin
      if (data_in_valid && weight_valid) begin
        s = 0;
        for (int i = 0; i < P; i++) begin
          s += longint'($signed(data_in[i])) * longint'($signed(weight[i]));
        end
        m_acc += s;
        m_beats++;
        if (m_beats == D) begin
          m_out   = conv(m_acc);
          m_emit  = 1'b1;
          m_beats = 0;
          m_acc   = 0;
        end
      end
    end else if (data_out_ready) begin
      m_emit = 1'b0;
    end
  end

  // Compare process: every cycle, on the falling edge.
  always @(negedge clk) begin
    if (check_en) begin
      chk("data_out_valid", 32'(data_out_valid), 32'(m_emit));
      chk("data_out", data_out, m_out);
      chk("data_in_ready", 32'(data_in_ready), 32'(!rst && !m_emit && weight_valid));
      chk("weight_ready", 32'(weight_ready), 32'(!rst && !m_emit && data_in_valid));
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic tick;
    @(negedge clk);
    #1;
  endtask

  task automatic set_lanes(input int a, input int w);
    for (int i = 0; i < P; i++) begin
      data_in[i] = 16'(a);
      weight[i]  = 16'(w);
    end
  endtask

  task automatic set_valids(input logic v);
    data_in_valid = v;
    weight_valid  = v;
  endtask

  // Waits (bounded) until a result handshake is pending and returns its value.
  task automatic wait_result(input string name, output logic [31:0] v, output int at_cyc);
    int k;
    k      = 0;
    v      = 'x;
    at_cyc = -1;
    while (!(data_out_valid && data_out_ready) && k < 60) begin
      tick;
      k++;
    end
    if (data_out_valid && data_out_ready) begin
      v      = data_out;
      at_cyc = cyc;
    end else begin
      checks++;
      errors++;
      $display("FAIL %s timeout actual=no_result required=result_within_60_cycles", name);
    end
  endtask

  logic [31:0] r0;
  logic [31:0] r1;
  int          c0;
  int          c1;
  bit          got;

  initial begin
    set_lanes(0, 0);
    set_valids(1'b1);
    data_out_ready = 1'b1;
    rst            = 1'b1;
    tick;
    check_en = 1'b1;
    tick;
    tick;

    // Reset state, with both valids high during reset.
    chk("reset_data_out", data_out, 32'd0);
    chk("reset_valid", 32'(data_out_valid), 32'd0);
    chk("reset_din_ready", 32'(data_in_ready), 32'd0);
    chk("reset_w_ready", 32'(weight_ready), 32'd0);

    // Basic: 1*2*4 lanes*8 beats = 64, back-to-back results IN_DEPTH+1 apart.
    set_lanes(1, 2);
    rst = 1'b0;
    wait_result("basic_r0", r0, c0);
    chk("basic_r0", r0, 32'd64);
    tick;
    wait_result("basic_r1", r1, c1);
    chk("basic_r1", r1, 32'd64);
    chk("basic_interval", 32'(c1 - c0), 32'd9);
    set_valids(1'b0);
    tick;

    // Signed: -3*5*4*8 = -480.
    set_lanes(-3, 5);
    set_valids(1'b1);
    wait_result("signed", r0, c0);
    chk("signed", r0, 32'hFFFF_FE20);
    set_valids(1'b0);
    tick;

    // Backpressure: 2*3*4*8 = 192, held for 5 cycles, then the next result.
    set_lanes(2, 3);
    data_out_ready = 1'b0;
    set_valids(1'b1);
    for (int k = 0; k < 30 && !data_out_valid; k++) tick;
    chk("bp_valid_up", 32'(data_out_valid), 32'd1);
    repeat (5) tick;
    chk("bp_held", data_out, 32'd192);
    chk("bp_din_ready_low", 32'(data_in_ready), 32'd0);
    data_out_ready = 1'b1;
    wait_result("bp_r0", r0, c0);
    chk("bp_r0", r0, 32'd192);
    tick;
    wait_result("bp_r1", r1, c1);
    chk("bp_r1", r1, 32'd192);
    set_valids(1'b0);
    tick;

    // Valid gaps: weight_valid toggles, data_in_valid drops on 3 cycles.
    set_lanes(1, 2);
    got = 1'b0;
    for (int k = 0; k < 80 && !got; k++) begin
      if (data_out_valid) begin
        r0  = data_out;
        got = 1'b1;
      end else begin
        weight_valid  = k[0];
        data_in_valid = !(k == 4 || k == 7 || k == 11);
        tick;
      end
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL gaps timeout actual=no_result required=result_within_80_cycles");
    end else begin
      chk("gaps", r0, 32'd64);
    end
    set_valids(1'b0);
    tick;

    // Mid-operation reset after 3 beats; the discarded beats must not leak.
    set_lanes(7, 9);
    set_valids(1'b1);
    repeat (3) tick;
    set_valids(1'b0);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    chk("midrst_valid", 32'(data_out_valid), 32'd0);
    set_lanes(1, 1);
    set_valids(1'b1);
    wait_result("midrst", r0, c0);
    chk("midrst", r0, 32'd32);
    set_valids(1'b0);
    tick;

    // Overflow: 32767^2 * 4 * 8 = 0x7_FFE0_0020.
    set_lanes(32767, 32767);
    set_valids(1'b1);
    wait_result("overflow", r0, c0);
`ifdef ACC_SATURATE_EN
    chk("overflow", r0, 32'h7FFF_FFFF);
`else
    chk("overflow", r0, 32'hFFE0_0020);
`endif
    set_valids(1'b0);
    tick;
    tick;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
